// File: rtl/dram_dma_pkg.sv
// Shared types and sizing helpers for the DRAM read DMA engine.
`timescale 1ns/1ps
package dram_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int bytes_per_beat(input int data_width);
    return data_width / 8;
  endfunction

  // One extra bit so a counter can hold MAX_OUTSTANDING itself.
  function automatic int credit_width(input int max_outstanding);
    return $clog2(max_outstanding) + 1;
  endfunction

endpackage

// File: rtl/rdma_beat_fifo.sv
// Small synchronous FIFO holding read beats between the R channel and the stream.
`timescale 1ns/1ps
module rdma_beat_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Head is forced to zero when empty so the stream data reads 0 after reset.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/dram_rdma_reader.sv
// AXI4 single-beat read master that streams a contiguous DRAM block out as AXI4-Stream.
`timescale 1ns/1ps
module dram_rdma_reader
  import dram_dma_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int LEN_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  num_words,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int BPB = bytes_per_beat(DATA_WIDTH);
  localparam int CW  = credit_width(MAX_OUTSTANDING);
  localparam logic [CW:0] MAX_CREDIT = (CW+1)'(MAX_OUTSTANDING);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  ar_left;
  logic [LEN_WIDTH-1:0]  out_left;
  logic [CW-1:0]         used;
  logic                  arvalid_q;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;

  logic                  ar_hs;
  logic                  r_hs;
  logic                  pop;
  logic [LEN_WIDTH-1:0]  ar_left_nxt;
  logic                  credit_ok;
  logic                  issue;

  assign ar_hs       = arvalid_q & m_axi_arready;
  assign r_hs        = (state == RUN) & m_axi_rvalid;
  assign pop         = ~fifo_empty & m_axis_tready;
  assign ar_left_nxt = ar_left - LEN_WIDTH'(ar_hs);
  // used counts reserved requests (pending AR plus in-flight R); with the FIFO
  // occupancy it bounds how many beats can ever land, so rready never drops.
  assign credit_ok   = ({1'b0, used} + {1'b0, fifo_count}) < MAX_CREDIT;
  assign issue       = (state == RUN) && (!arvalid_q || ar_hs) &&
                       (ar_left_nxt != '0) && credit_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      ar_left   <= '0;
      out_left  <= '0;
      used      <= '0;
      arvalid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (num_words != '0) begin
              addr_q    <= base_addr;
              ar_left   <= num_words;
              out_left  <= num_words;
              arvalid_q <= 1'b1;
              used      <= CW'(1);
              state     <= RUN;
            end else begin
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (ar_hs) begin
            addr_q  <= addr_q + ADDR_WIDTH'(BPB);
            ar_left <= ar_left_nxt;
          end
          arvalid_q <= issue | (arvalid_q & ~ar_hs);
          used      <= used + CW'(issue) - CW'(r_hs);
          if (pop) begin
            out_left <= out_left - 1'b1;
            if (out_left == LEN_WIDTH'(1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  rdma_beat_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (r_hs),
    .pop   (pop),
    .din   (m_axi_rdata),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign busy          = (state == RUN);
  assign done          = (state == DONE);
  assign m_axi_rready  = (state == RUN);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_dout;
  assign m_axis_tlast  = (out_left == LEN_WIDTH'(1)) & ~fifo_empty;

endmodule
